// File: rtl/audio_stream_pkg.sv
// Shared types and constants for the audio streaming path.
package audio_stream_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR,
        ST_SEQ,
        ST_POP,
        ST_DATA,
        ST_WAIT_HI,
        ST_WAIT_LO
    } framer_state_t;

    localparam logic [7:0] SYNC_BYTE_DEFAULT  = 8'hA5;
    localparam int         AUDIO_SAMPLE_WIDTH = 24;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered read data; storage maps to distributed RAM.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 16
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             wr_en;
    logic             rd_en;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    // A pop in the same cycle frees a slot, so a full FIFO still accepts the push.
    assign wr_en = push && (!full || pop);
    assign rd_en = pop && !empty;

    always_ff @(posedge clk_in) begin
        if (wr_en) begin
            mem[wr_ptr] <= push_data;
        end
        if (rd_en) begin
            rd_data <= mem[rd_ptr];
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_en) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({wr_en, rd_en})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/audio_uart_framer.sv
// Buffers audio samples and emits framed bytes (sync, sequence, sample MSBs) to a byte UART.
module audio_uart_framer
    import audio_stream_pkg::*;
#(
    parameter int         SAMPLE_WIDTH      = AUDIO_SAMPLE_WIDTH,
    parameter int         BYTES_PER_SAMPLE  = 2,
    parameter int         SAMPLES_PER_FRAME = 8,
    parameter int         FIFO_DEPTH        = 16,
    parameter logic [7:0] SYNC_BYTE         = SYNC_BYTE_DEFAULT
) (
    input  logic                          clk_in,
    input  logic                          rst_in,
    input  logic [SAMPLE_WIDTH-1:0]       audio_in,
    input  logic                          valid_in,
    input  logic                          enable_in,
    input  logic                          busy_in,
    output logic [7:0]                    byte_out,
    output logic                          trigger_out,
    output logic [7:0]                    seq_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count_out,
    output logic [15:0]                   drop_count_out
);

    localparam int FW    = 8 * BYTES_PER_SAMPLE;
    localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;
    localparam int BI_W  = (BYTES_PER_SAMPLE > 1) ? $clog2(BYTES_PER_SAMPLE) : 1;
    localparam int SI_W  = (SAMPLES_PER_FRAME > 1) ? $clog2(SAMPLES_PER_FRAME) : 1;
    localparam logic [CNT_W-1:0] FRAME_FILL  = CNT_W'(SAMPLES_PER_FRAME);
    localparam logic [BI_W-1:0]  LAST_BYTE   = BI_W'(BYTES_PER_SAMPLE - 1);
    localparam logic [SI_W-1:0]  LAST_SAMPLE = SI_W'(SAMPLES_PER_FRAME - 1);

    framer_state_t   state, state_nxt;
    framer_state_t   ret_state, ret_nxt;
    logic [BI_W-1:0] byte_idx, byte_idx_nxt;
    logic [SI_W-1:0] samp_idx, samp_idx_nxt;
    logic [7:0]      seq_nxt;
    logic [7:0]      byte_nxt;
    logic            trig_nxt;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic [FW-1:0]   fifo_rd_data;
    logic [7:0]      data_byte;

    generate
        if (SAMPLE_WIDTH > FW) begin : g_lsb
            logic audio_lsb_unused;
            assign audio_lsb_unused = ^audio_in[SAMPLE_WIDTH-FW-1:0];
        end
    endgenerate

    assign fifo_pop = (state == ST_POP) && !fifo_empty;

    sync_fifo #(
        .WIDTH (FW),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (valid_in),
        .push_data (audio_in[SAMPLE_WIDTH-1 -: FW]),
        .pop       (fifo_pop),
        .rd_data   (fifo_rd_data),
        .count     (fifo_count_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // The FIFO read register doubles as the sample shift register; byte_idx selects MSB-first.
    always_comb begin
        data_byte = fifo_rd_data[FW-1 -: 8];
        for (int i = 1; i < BYTES_PER_SAMPLE; i++) begin
            if (byte_idx == BI_W'(i)) begin
                data_byte = fifo_rd_data[FW-1-8*i -: 8];
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        ret_nxt      = ret_state;
        byte_idx_nxt = byte_idx;
        samp_idx_nxt = samp_idx;
        seq_nxt      = seq_out;
        trig_nxt     = 1'b0;
        byte_nxt     = byte_out;
        case (state)
            // The sync byte is registered on the way into HDR so it fires one cycle after the start condition.
            ST_IDLE: begin
                if (enable_in && (fifo_count_out >= FRAME_FILL) && !busy_in) begin
                    trig_nxt     = 1'b1;
                    byte_nxt     = SYNC_BYTE;
                    byte_idx_nxt = '0;
                    samp_idx_nxt = '0;
                    state_nxt    = ST_HDR;
                end
            end
            ST_HDR: begin
                ret_nxt   = ST_SEQ;
                state_nxt = ST_WAIT_HI;
            end
            ST_SEQ: begin
                trig_nxt  = 1'b1;
                byte_nxt  = seq_out;
                ret_nxt   = ST_POP;
                state_nxt = ST_WAIT_HI;
            end
            ST_POP: begin
                state_nxt = ST_DATA;
            end
            ST_DATA: begin
                trig_nxt  = 1'b1;
                byte_nxt  = data_byte;
                state_nxt = ST_WAIT_HI;
                if (byte_idx != LAST_BYTE) begin
                    byte_idx_nxt = byte_idx + 1'b1;
                    ret_nxt      = ST_DATA;
                end else if (samp_idx != LAST_SAMPLE) begin
                    byte_idx_nxt = '0;
                    samp_idx_nxt = samp_idx + 1'b1;
                    ret_nxt      = ST_POP;
                end else begin
                    byte_idx_nxt = '0;
                    samp_idx_nxt = '0;
                    seq_nxt      = seq_out + 8'd1;
                    ret_nxt      = ST_IDLE;
                end
            end
            ST_WAIT_HI: begin
                if (busy_in) begin
                    state_nxt = ST_WAIT_LO;
                end
            end
            ST_WAIT_LO: begin
                if (!busy_in) begin
                    state_nxt = ret_state;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state       <= ST_IDLE;
            ret_state   <= ST_IDLE;
            byte_idx    <= '0;
            samp_idx    <= '0;
            seq_out     <= '0;
            trigger_out <= 1'b0;
            byte_out    <= '0;
        end else begin
            state       <= state_nxt;
            ret_state   <= ret_nxt;
            byte_idx    <= byte_idx_nxt;
            samp_idx    <= samp_idx_nxt;
            seq_out     <= seq_nxt;
            trigger_out <= trig_nxt;
            byte_out    <= byte_nxt;
        end
    end

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            drop_count_out <= '0;
        end else if (valid_in && fifo_full && !fifo_pop && (drop_count_out != 16'hFFFF)) begin
            drop_count_out <= drop_count_out + 16'd1;
        end
    end

endmodule

// File: tb/tb_audio_uart_framer.sv
// Randomized bench for audio_uart_framer against a frame-level reference model.
module tb_audio_uart_framer;

    localparam int SW    = 24;
    localparam int BPS   = 2;
    localparam int SPF   = 2;
    localparam int DEPTH = 16;

    logic        clk_in = 1'b0;
    logic        rst_in;
    logic [SW-1:0] audio_in;
    logic        valid_in;
    logic        enable_in;
    logic        busy_in;
    logic [7:0]  byte_out;
    logic        trigger_out;
    logic [7:0]  seq_out;
    logic [4:0]  fifo_count_out;
    logic [15:0] drop_count_out;

    always #5 clk_in = ~clk_in;

    audio_uart_framer #(
        .SAMPLE_WIDTH      (SW),
        .BYTES_PER_SAMPLE  (BPS),
        .SAMPLES_PER_FRAME (SPF),
        .FIFO_DEPTH        (DEPTH),
        .SYNC_BYTE         (8'hA5)
    ) dut (
        .clk_in         (clk_in),
        .rst_in         (rst_in),
        .audio_in       (audio_in),
        .valid_in       (valid_in),
        .enable_in      (enable_in),
        .busy_in        (busy_in),
        .byte_out       (byte_out),
        .trigger_out    (trigger_out),
        .seq_out        (seq_out),
        .fifo_count_out (fifo_count_out),
        .drop_count_out (drop_count_out)
    );

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference model: queued sample MSBs, pending frame bytes, sequence and drop counters.
    logic [15:0] model_q[$];
    logic [7:0]  exp_q[$];
    logic [7:0]  cap_q[$];
    int model_seq   = 0;
    int model_drops = 0;
    int frames_done = 0;
    int trig_count  = 0;

    task automatic model_push(input logic [SW-1:0] s);
        if (model_q.size() < DEPTH) model_q.push_back(s[SW-1 -: 16]);
        else if (model_drops < 65535) model_drops++;
    endtask

    function automatic void build_frame();
        logic [15:0] w;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'(model_seq));
        for (int i = 0; i < SPF; i++) begin
            w = model_q.pop_front();
            for (int b = 0; b < BPS; b++) exp_q.push_back(8'(w >> (8 * (BPS - 1 - b))));
        end
        model_seq = (model_seq + 1) % 256;
    endfunction

    always @(negedge clk_in) begin
        if (!rst_in && trigger_out) begin
            trig_count++;
            cap_q.push_back(byte_out);
            chk("busy_at_trigger", busy_in, 0);
            if (exp_q.size() == 0 && model_q.size() < SPF) begin
                chk("frame_start_samples", model_q.size(), SPF);
            end else begin
                if (exp_q.size() == 0) build_frame();
                chk("frame_byte", byte_out, exp_q.pop_front());
                if (exp_q.size() == 0) frames_done++;
            end
        end
    end

    // Transmitter model: busy rises the cycle after a trigger and stays high busy_len cycles (0 = random 1..4).
    int   busy_len  = 10;
    int   tx_cnt    = 0;
    logic trig_seen = 1'b0;
    initial busy_in = 1'b0;
    always @(posedge clk_in) begin
        #2;
        if (tx_cnt > 0) tx_cnt--;
        if (trig_seen) tx_cnt = (busy_len == 0) ? int'($urandom_range(1, 4)) : busy_len;
        trig_seen = trigger_out;
        busy_in   = (tx_cnt > 0);
    end

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic push(input logic [SW-1:0] s);
        valid_in = 1'b1;
        audio_in = s;
        tick();
        valid_in = 1'b0;
        model_push(s);
    endtask

    task automatic wait_frames(input int n, input int budget);
        for (int i = 0; i < budget && frames_done < n; i++) tick();
        if (frames_done < n) chk("timeout_frames", frames_done, n);
    endtask

    task automatic wait_trig(input int n, input int budget, input string tag);
        for (int i = 0; i < budget && trig_count < n; i++) begin
            @(negedge clk_in);
            #1;
        end
        if (trig_count < n) chk(tag, trig_count, n);
    endtask

    logic [7:0] basic_exp [6] = '{8'hA5, 8'h00, 8'h12, 8'h34, 8'hAB, 8'hCD};
    int t0, t1, f0, gap, c;
    logic [SW-1:0] s;

    initial begin
        rst_in    = 1'b1;
        valid_in  = 1'b0;
        enable_in = 1'b0;
        audio_in  = '0;
        repeat (3) tick();
        chk("rst_byte", byte_out, 0);
        chk("rst_trigger", trigger_out, 0);
        chk("rst_seq", seq_out, 0);
        chk("rst_count", fifo_count_out, 0);
        chk("rst_drop", drop_count_out, 0);
        rst_in = 1'b0;
        tick();

        // Basic frame
        enable_in = 1'b1;
        push(24'h123456);
        push(24'hABCDEF);
        wait_frames(1, 1000);
        if (cap_q.size() < 6) chk("basic_len", cap_q.size(), 6);
        else for (int i = 0; i < 6; i++) chk("basic_byte", cap_q[i], basic_exp[i]);
        repeat (20) tick();
        chk("basic_seq", seq_out, 1);
        chk("basic_count", fifo_count_out, 0);

        // Overflow with framing disabled
        enable_in = 1'b0;
        t0 = trig_count;
        for (int i = 0; i < 18; i++) begin
            push(24'($urandom));
            chk("ovf_count", fifo_count_out, model_q.size());
        end
        chk("ovf_full", fifo_count_out, DEPTH);
        chk("ovf_drops", drop_count_out, model_drops);
        chk("ovf_no_trigger", trig_count, t0);
        f0 = frames_done;
        enable_in = 1'b1;
        wait_frames(f0 + 8, 4000);
        repeat (20) tick();
        chk("ovf_drained", fifo_count_out, 0);

        // Busy stall after the sync byte
        enable_in = 1'b0;
        push(24'($urandom));
        push(24'($urandom));
        f0 = frames_done;
        t0 = trig_count;
        busy_len  = 500;
        enable_in = 1'b1;
        wait_trig(t0 + 1, 50, "stall_first_trigger");
        c = 0;
        while (!busy_in && c < 10) begin
            @(negedge clk_in);
            #1;
            c++;
        end
        busy_len = 10;
        t1 = trig_count;
        c = 0;
        while (busy_in && c < 700) begin
            @(negedge clk_in);
            #1;
            c++;
        end
        chk("stall_quiet", trig_count, t1);
        gap = 0;
        while (trig_count == t1 && gap < 10) begin
            @(negedge clk_in);
            #1;
            gap++;
        end
        chk("stall_resume_gap", gap, 2);
        wait_frames(f0 + 1, 1000);

        // Enable dropped after the sync byte
        enable_in = 1'b0;
        repeat (4) push(24'($urandom));
        f0 = frames_done;
        t0 = trig_count;
        enable_in = 1'b1;
        wait_trig(t0 + 1, 50, "en_first_trigger");
        enable_in = 1'b0;
        wait_frames(f0 + 1, 1000);
        t1 = trig_count;
        repeat (200) tick();
        chk("en_no_next_frame", trig_count, t1);
        chk("en_held_count", fifo_count_out, 2);
        enable_in = 1'b1;
        wait_frames(f0 + 2, 1000);

        // Random traffic through sequence wrap
        busy_len = 0;
        for (int i = 0; i < 60000 && frames_done < 260; i++) begin
            if ($urandom_range(0, 2) == 0 && model_q.size() < DEPTH - 2) begin
                s = 24'($urandom);
                push(s);
            end else begin
                tick();
            end
        end
        if (frames_done < 260) chk("timeout_wrap", frames_done, 260);
        enable_in = 1'b0;
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) tick();
        repeat (10) tick();
        chk("wrap_seq", seq_out, model_seq);
        chk("wrap_drops", drop_count_out, model_drops);

        // Reset mid-frame
        busy_len = 10;
        push(24'($urandom));
        push(24'($urandom));
        t0 = trig_count;
        enable_in = 1'b1;
        wait_trig(t0 + 3, 500, "rst_mid_trigger");
        rst_in = 1'b1;
        @(negedge clk_in);
        #1;
        chk("rstmid_byte", byte_out, 0);
        chk("rstmid_trigger", trigger_out, 0);
        chk("rstmid_seq", seq_out, 0);
        chk("rstmid_count", fifo_count_out, 0);
        chk("rstmid_drop", drop_count_out, 0);
        exp_q.delete();
        model_q.delete();
        model_seq   = 0;
        model_drops = 0;
        rst_in = 1'b0;
        t1 = trig_count;
        repeat (50) tick();
        chk("rstmid_quiet", trig_count, t1);
        f0 = frames_done;
        push(24'($urandom));
        push(24'($urandom));
        wait_frames(f0 + 1, 1000);
        repeat (20) tick();
        chk("rstmid_seq_after", seq_out, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
